fulladder_seq_ctrl: RTL and testbench
=====================================

// Module: fulladder_seq_ctrl
// PURPOSE
//   Multi-cycle wide-operand adder controller. Splits a W = N*K bit addition
//   into K slices of N bits and drives them least-significant slice first
//   through the team's combinational N-bit ripple adder (fulladder #(N)).
//   The carry is chained through a register, so a wide add reuses one N-bit
//   adder. This block sits on both sides of that adder: it feeds a/b/cin and
//   captures sum/cout.
// PARAMETERS
//   N  4  slice width; must equal the N of the attached fulladder
//   K  4  number of slices; W = N*K (16 by default); K >= 2
// PORTS
//   clk       in   1  single clock, rising edge
//   rst_n     in   1  asynchronous, active-low reset
//   start     in   1  request; accepted only when busy == 0
//   op_a      in   W  operand A, sampled on the accepting edge
//   op_b      in   W  operand B, sampled on the accepting edge
//   cin       in   1  carry-in, sampled on the accepting edge
//   busy      out  1  high in RUN and DONE
//   done      out  1  one-cycle pulse; result and cout_o are valid
//   result    out  W  wide sum; held until the next accepted start
//   cout_o    out  1  final carry-out; held with result
//   add_a     out  N  to fulladder a
//   add_b     out  N  to fulladder b
//   add_cin   out  1  to fulladder cin
//   add_sum   in   N  from fulladder sum
//   add_cout  in   1  from fulladder cout
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous): state=IDLE; idx=0; carry_q=0.
//   result=0, cout_o=0, busy=0, done=0, add_a=0, add_b=0, add_cin=0.
// - FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: on an edge with start=1, latch op_a, op_b and cin (into carry_q).
//     Clear result and cout_o to 0, set idx=0, go to RUN.
//   RUN: combinationally drive add_a=a_q[idx*N +: N], add_b=b_q[idx*N +: N],
//     add_cin=carry_q.
//     Each edge: result[idx*N +: N] <= add_sum; carry_q <= add_cout; idx++.
//     On the edge with idx==K-1: cout_o <= add_cout; go to DONE.
//   DONE: done=1 for exactly one cycle; unconditionally return to IDLE.
// - Latency: the accepting edge is E0. Slices are written on E1..EK.
//   done is high between EK and EK+1. Next start can be accepted at EK+2.
// - start while busy (RUN or DONE) is ignored, with no queueing. Operand
//   inputs may change freely after E0.
// - add_a, add_b and add_cin are 0 outside RUN. The adder path is
//   combinational within one cycle, so there is no extra pipeline stage.
// - Arithmetic: result = (op_a + op_b + cin) mod 2^W; cout_o = bit W of the
//   full sum. Wrap-around is silent; there is no overflow flag.
// - Reset mid-operation aborts immediately: outputs return to reset values,
//   done never pulses for the aborted op, and the next start behaves as
//   after power-up.
// - idx is ceil(log2(K)) bits wide and never exceeds K-1.
// TESTING (N=4, K=4, bench instantiates fulladder #(4) on the add_* ports)
// 1. Hold rst_n=0 -> all outputs 0. Release; start=0 for 5 cycles ->
//    busy=0, done=0.
// 2. op_a=16'h0001, op_b=16'h0001, cin=0, start for 1 cycle -> busy=1 from
//    E0. done pulses exactly 4 cycles after E0; result=16'h0002, cout_o=0.
// 3. op_a=16'h00FF, op_b=16'h0001, cin=0 -> result=16'h0100, cout_o=0.
//    Check add_cin=1 while slices 1 and 2 are driven.
// 4. op_a=16'hFFFF, op_b=16'h0000, cin=1 -> result=16'h0000, cout_o=1.
//    Then op_a=16'h1234, op_b=16'h4321, cin=1 -> result=16'h5556, cout_o=0.
// 5. Start 16'h0003+16'h0004; re-assert start with 16'hAAAA+16'h5555 two
//    cycles later -> second request ignored; result=16'h0007 and only one
//    done pulse.
// 6. Start 16'h0F0F+16'h0101; drop rst_n for 1 cycle after E2 -> busy=0,
//    result=0, no done. A following 16'h0002+16'h0003 -> 16'h0005.

Source files
------------

// File: rtl/fulladder_seq_ctrl.sv
// Multi-cycle wide adder controller: walks K slices of N bits through one
// external N-bit ripple adder, least-significant slice first, chaining carry.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start             request, accepted only while busy == 0
//   op_a, op_b, cin   W-bit operands and carry-in, sampled when accepted
//   busy, done        busy in RUN/DONE; done is a one-cycle result strobe
//   result, cout_o    wide sum and final carry, held until next accept
//   add_a/add_b/add_cin  slice operands driven to the attached adder
//   add_sum/add_cout     slice sum and carry returned by the adder
module fulladder_seq_ctrl #(
    parameter  int N  = 4,
    parameter  int K  = 4,
    localparam int W  = N * K,
    localparam int IW = (K > 1) ? $clog2(K) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout_o,
    output logic [N-1:0] add_a,
    output logic [N-1:0] add_b,
    output logic         add_cin,
    input  logic [N-1:0] add_sum,
    input  logic         add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    carry_d  = cin;
                    result_d = '0;
                    cout_d   = 1'b0;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // The adder is purely combinational, so the slice sum
                // and carry are captured on the same edge they are driven.
                add_a   = a_q[idx_q*N +: N];
                add_b   = b_q[idx_q*N +: N];
                add_cin = carry_q;
                result_d[idx_q*N +: N] = add_sum;
                carry_d = add_cout;
                if (idx_q == IDX_LAST) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_fulladder_seq_ctrl.sv
// Self-checking bench for fulladder_seq_ctrl (N=4, K=4) with a
// behavioural slice adder on the add_* ports.
module tb_fulladder_seq_ctrl;

    localparam int N = 4;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout_o;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N-1:0] add_sum;
    logic         add_cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b}
                               + {4'b0, add_cin};

    fulladder_seq_ctrl #(.N(N), .K(K)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout_o   (cout_o),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: carry entering slice i is bit 4i of the sum of the
    // low 4i bits of each operand plus cin.
    function automatic logic slice_cin(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic c, input int i);
        logic [31:0] mask;
        logic [31:0] s;
        mask = (32'd1 << (N * i)) - 32'd1;
        s = (a & mask) + (b & mask) + {31'd0, c};
        return s[N*i];
    endfunction

    // One full operation; with collide=1 a second start arrives two
    // cycles after acceptance and must be ignored.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit collide);
        logic [W:0] full;
        logic [31:0] a32, b32;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        a32 = {16'd0, a};
        b32 = {16'd0, b};
        @(negedge clk);
        op_a = a;
        op_b = b;
        cin = c;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op_a = W'($urandom);
        op_b = W'($urandom);
        cin = 1'($urandom);
        for (int i = 0; i < K; i++) begin
            if (i > 0) @(negedge clk);
            if (collide && i == 2) begin
                start = 1'b1;
                op_a = 16'hAAAA;
                op_b = 16'h5555;
            end
            if (collide && i == 3) start = 1'b0;
            chk($sformatf("busy_run%0d", i), 32'(busy), 32'd1);
            chk($sformatf("done_run%0d", i), 32'(done), 32'd0);
            chk($sformatf("add_a%0d", i), 32'(add_a), 32'(a[i*N +: N]));
            chk($sformatf("add_b%0d", i), 32'(add_b), 32'(b[i*N +: N]));
            chk($sformatf("add_cin%0d", i), 32'(add_cin),
                32'(slice_cin(a32, b32, c, i)));
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd1);
        chk("result", 32'(result), 32'(full[W-1:0]));
        chk("cout_o", 32'(cout_o), 32'(full[W]));
        chk("add_a_idle", 32'(add_a), 32'd0);
        @(negedge clk);
        chk("done_end", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("result_hold", 32'(result), 32'(full[W-1:0]));
        chk("add_cin_idle", 32'(add_cin), 32'd0);
    endtask

    initial begin
        int seen_done;

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout_o), 32'd0);
        chk("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
        end

        // Directed operations
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        run_op(16'h1234, 16'h4321, 1'b1, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

        // Start while busy is ignored
        run_op(16'h0003, 16'h0004, 1'b0, 1'b1);
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("no_second_done", 32'(seen_done), 32'd0);
        chk("result_kept", 32'(result), 32'h0007);

        // Reset mid-operation
        @(negedge clk);
        op_a = 16'h0F0F;
        op_b = 16'h0101;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_add", 32'({add_a, add_b, add_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        run_op(16'h0002, 16'h0003, 1'b0, 1'b0);

        // Random operations
        for (int t = 0; t < 12; t++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
